// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: frame-sequencer state, mux_sel encodings and default width (STOP2 only with UART_TX_CTRL_TWO_STOP_EN)
package uart_tx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_CTRL_TWO_STOP_EN
    , STOP2
`endif
  } state_t;
  function automatic logic [1:0] mux_of(state_t s);
    return s == START ? MUX_START : s == DATA ? MUX_DATA : s == PARITY ? MUX_PAR : MUX_STOP;
  endfunction
endpackage

// File: rtl/uart_tx_watchdog.sv
// uart_tx_watchdog: counts DATA cycles and flags the last one allowed before a serializer timeout
module uart_tx_watchdog #(
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT_SLACK = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int LIMIT = DATA_WIDTH + TIMEOUT_SLACK;
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK)
    cnt <= (RST || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  // cnt holds completed DATA cycles, so the current one is the LIMIT-th when cnt == LIMIT-1
  assign expire = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer driving serializer load/shift and output mux select
// UART_TX_CTRL_TWO_STOP_EN adds the STOP2_EN input and a second stop bit.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int TIMEOUT_SLACK = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       ser_done,
`ifdef UART_TX_CTRL_TWO_STOP_EN
  input  logic       STOP2_EN,
`endif
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       par_typ_lat,
  output logic       busy,
  output logic       err_timeout
);
  state_t state, nxt;
  logic par_en_q, expire, last_stop;
`ifdef UART_TX_CTRL_TWO_STOP_EN
  logic stop2_q;
  assign last_stop = state == STOP2 || (state == STOP && !stop2_q);
`else
  assign last_stop = state == STOP;
`endif
  assign ser_load = !RST && Data_Valid && (state == IDLE || last_stop);
  uart_tx_watchdog #(.DATA_WIDTH(DATA_WIDTH), .TIMEOUT_SLACK(TIMEOUT_SLACK)) u_wd (
    .CLK(CLK), .RST(RST), .clr(state != DATA), .en(state == DATA), .expire(expire)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ser_load ? START : IDLE;
      START:   nxt = DATA;
      DATA:    nxt = ser_done ? (par_en_q ? PARITY : STOP) : expire ? STOP : DATA;
      PARITY:  nxt = STOP;
`ifdef UART_TX_CTRL_TWO_STOP_EN
      STOP:    nxt = stop2_q ? STOP2 : ser_load ? START : IDLE;
`endif
      default: nxt = ser_load ? START : IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ser_en      <= 1'b0;
      mux_sel     <= MUX_STOP;
      par_typ_lat <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      par_en_q    <= 1'b0;
`ifdef UART_TX_CTRL_TWO_STOP_EN
      stop2_q     <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      ser_en      <= nxt == DATA;
      mux_sel     <= mux_of(nxt);
      busy        <= nxt != IDLE;
      err_timeout <= state == DATA && !ser_done && expire;
      if (ser_load) begin
        par_en_q    <= PAR_EN;
        par_typ_lat <= PAR_TYP;
`ifdef UART_TX_CTRL_TWO_STOP_EN
        stop2_q     <= STOP2_EN;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized frame-level checks of uart_tx_ctrl against a per-frame timeline model
module tb_uart_tx_ctrl;
  localparam int LIM = 10;
  logic CLK = 1'b0, RST = 1'b1, Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0, ser_done = 1'b0, stop2_en = 1'b0;
  logic ser_load, ser_en, par_typ_lat, busy, err_timeout;
  logic [1:0] mux_sel;
  int n_cmp = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  uart_tx_ctrl dut (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done),
`ifdef UART_TX_CTRL_TWO_STOP_EN
    .STOP2_EN(stop2_en),
`endif
    .ser_load(ser_load), .ser_en(ser_en), .mux_sel(mux_sel), .par_typ_lat(par_typ_lat), .busy(busy),
    .err_timeout(err_timeout)
  );

  // Model: a frame is START, n DATA cycles, PARITY if enabled and no timeout, STOP, optional STOP2.
  task automatic run_frame(input bit from_idle, input bit pe, input bit pt, input bit s2, input int done_at,
                           input bit chain, input bit npe, input bit npt, input bit ns2, output int loads);
    int n, len;
    bit to, ep;
    logic [1:0] em;
    to = !(done_at >= 1 && done_at <= LIM);
    n = to ? LIM : done_at;
    ep = pe && !to;
    len = 1 + n + int'(ep) + 1 + int'(s2);
    loads = 0;
    if (from_idle) begin
      @(negedge CLK);
      n_cmp++; if (mux_sel !== 2'b01 || busy !== 1'b0) begin n_bad++;
        $display("FAIL idle_before mux=%b busy=%b expected mux=01 busy=0", mux_sel, busy); end
      Data_Valid = 1'b1; PAR_EN = pe; PAR_TYP = pt; stop2_en = s2; ser_done = 1'($urandom);
      #1;
      n_cmp++; if (ser_load !== 1'b1) begin n_bad++;
        $display("FAIL accept_load ser_load=%b expected 1", ser_load); end
      loads += int'(ser_load);
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge CLK);
      em = k == 1 ? 2'b00 : k <= n + 1 ? 2'b10 : (k == n + 2 && ep) ? 2'b11 : 2'b01;
      n_cmp++; if (mux_sel !== em) begin n_bad++;
        $display("FAIL mux_sel cycle %0d got %b expected %b", k, mux_sel, em); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++;
        $display("FAIL busy cycle %0d got %b expected 1", k, busy); end
      n_cmp++; if (ser_en !== (k >= 2 && k <= n + 1)) begin n_bad++;
        $display("FAIL ser_en cycle %0d got %b expected %b", k, ser_en, (k >= 2 && k <= n + 1)); end
      n_cmp++; if (err_timeout !== (to && k == n + 2)) begin n_bad++;
        $display("FAIL err_timeout cycle %0d got %b expected %b", k, err_timeout, (to && k == n + 2)); end
      n_cmp++; if (par_typ_lat !== pt) begin n_bad++;
        $display("FAIL par_typ_lat cycle %0d got %b expected %b", k, par_typ_lat, pt); end
      Data_Valid = k == len ? chain : 1'($urandom);
      PAR_EN = (k == len && chain) ? npe : 1'($urandom);
      PAR_TYP = (k == len && chain) ? npt : 1'($urandom);
      stop2_en = (k == len && chain) ? ns2 : 1'($urandom);
      ser_done = (k >= 2 && k <= n + 1) ? (k - 1 == done_at) : 1'($urandom);
      #1;
      n_cmp++; if (ser_load !== (k == len && chain)) begin n_bad++;
        $display("FAIL ser_load cycle %0d got %b expected %b", k, ser_load, (k == len && chain)); end
      loads += int'(ser_load);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Data_Valid = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++; if ({mux_sel, busy, ser_en, err_timeout, par_typ_lat, ser_load} !== 7'b01_00000) begin n_bad++;
      $display("FAIL reset_state got %b expected 0100000", {mux_sel, busy, ser_en, err_timeout, par_typ_lat, ser_load}); end
    RST = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    @(negedge CLK);
    Data_Valid = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b1; ser_done = 1'b0;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    n_cmp++; if (ser_en !== 1'b1 || mux_sel !== 2'b10) begin n_bad++;
      $display("FAIL mid_data_pre ser_en=%b mux=%b expected 1 10", ser_en, mux_sel); end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++; if ({mux_sel, busy, ser_en, err_timeout, par_typ_lat} !== 6'b01_0000) begin n_bad++;
      $display("FAIL mid_data_reset got %b expected 010000", {mux_sel, busy, ser_en, err_timeout, par_typ_lat}); end
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_bad++;
      $display("FAIL post_reset_idle busy=%b mux=%b expected 0 01", busy, mux_sel); end
  endtask

  task automatic test_basic();
    int l;
    run_frame(1, 0, 0, 0, 8, 0, 0, 0, 0, l);
    run_frame(1, 1, 1, 0, 8, 0, 0, 0, 0, l);
  endtask

  task automatic test_back_to_back();
    int l1, l2;
    run_frame(1, 0, 1, 0, 8, 1, 1, 0, 0, l1);
    run_frame(0, 1, 0, 0, 8, 0, 0, 0, 0, l2);
    n_cmp++; if (l1 + l2 !== 2) begin n_bad++;
      $display("FAIL b2b_load_count got %0d expected 2", l1 + l2); end
  endtask

  task automatic test_timeout_and_bounds();
    int l;
    run_frame(1, 1, 0, 0, 0, 0, 0, 0, 0, l);
    run_frame(1, 1, 1, 0, 1, 0, 0, 0, 0, l);
    run_frame(1, 1, 0, 0, LIM, 0, 0, 0, 0, l);
    run_frame(1, 0, 1, 0, LIM + 1, 0, 0, 0, 0, l);
  endtask

  task automatic test_random();
    int l;
    bit fi, pe, pt, ch, npe, npt;
    fi = 1; pe = 1'($urandom); pt = 1'($urandom);
    for (int i = 0; i < 30; i++) begin
      ch = i < 29 && ($urandom % 2 == 1);
      npe = 1'($urandom); npt = 1'($urandom);
      run_frame(fi, pe, pt, 0, $urandom_range(0, LIM + 2), ch, npe, npt, 0, l);
      fi = !ch; pe = ch ? npe : 1'($urandom); pt = ch ? npt : 1'($urandom);
    end
    @(negedge CLK);
    n_cmp++; if (busy !== 1'b0 || mux_sel !== 2'b01) begin n_bad++;
      $display("FAIL final_idle busy=%b mux=%b expected 0 01", busy, mux_sel); end
  endtask

`ifdef UART_TX_CTRL_TWO_STOP_EN
  task automatic test_two_stop();
    int l1, l2;
    run_frame(1, 0, 0, 1, 8, 1, 1, 1, 1, l1);
    run_frame(0, 1, 1, 1, 8, 0, 0, 0, 0, l2);
    n_cmp++; if (l1 + l2 !== 2) begin n_bad++;
      $display("FAIL two_stop_load_count got %0d expected 2", l1 + l2); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_data();
    test_basic();
    test_back_to_back();
    test_timeout_and_bounds();
`ifdef UART_TX_CTRL_TWO_STOP_EN
    test_two_stop();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
